// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/select bundle between requesters and the arbiter.
// The arbiter side uses master and the requester side uses slave.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic       s1;
  logic       s2;
  logic       busy;

  modport master (
    input  req,
    output grant,
    output s1,
    output s2,
    output busy
  );

  modport slave (
    output req,
    input  grant,
    input  s1,
    input  s2,
    input  busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin grant sequencer in front of a 4:1 mux select.
// Each grant is bounded by HOLD_MAX and followed by one idle cycle.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux4_rr_arbiter_if.master bus
);
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_ptr;
  logic [1:0]    w_ptr_nxt;
  logic [1:0]    r_sel;
  logic [1:0]    w_sel_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_win;
  logic [1:0]    w_idx;
  logic          w_release;
  logic [3:0]    w_grant;

  // Winner search starts just after ptr; ptr itself is tried last.
  always_comb begin
    w_win = r_ptr;
    w_idx = r_ptr;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_ptr + 2'(k);
      if (bus.req[w_idx]) begin
        w_win = w_idx;
      end
    end
  end

  assign w_release = !bus.req[r_ptr] || (r_cnt == LP_LAST);

  // Next-state logic for grant sequencing and hold counting.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_state_nxt = BUSY;
          w_ptr_nxt   = w_win;
          w_sel_nxt   = w_win;
          w_cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, pointer, select and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 2'd3;
      r_sel   <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Grant is decoded from state so it clears with reset at once.
  always_comb begin
    w_grant = 4'b0000;
    if (r_state == BUSY) begin
      w_grant[r_ptr] = 1'b1;
    end
  end

  assign bus.grant = w_grant;
  assign bus.busy  = (r_state == BUSY);
  assign bus.s1    = r_sel[1];
  assign bus.s2    = r_sel[0];
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random requests
// compared cycle by cycle against an owner/elapsed-time reference model.
module tb_mux4_rr_arbiter;
  localparam int HOLD = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  int   m_owner;
  int   m_held;
  int   m_last;
  int   m_sel;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 3;
    m_sel   = 0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    if (m_owner < 0) begin
      if (r != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (m_owner < 0 && r[(m_last + k) % 4]) begin
            m_owner = (m_last + k) % 4;
          end
        end
        m_last = m_owner;
        m_sel  = m_owner;
        m_held = 1;
      end
    end else if (!r[m_owner] || m_held == HOLD) begin
      m_owner = -1;
    end else begin
      m_held++;
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    check({tag, ".grant"}, {4'b0, bus.grant}, {4'b0, eg});
    check({tag, ".sel"}, {6'b0, bus.s1, bus.s2}, 8'(m_sel));
    check({tag, ".busy"}, {7'b0, bus.busy}, {7'b0, m_owner >= 0});
  endtask

  task automatic step(input logic [3:0] r, input string tag);
    bus.req = r;
    @(posedge clk);
    if (rst_n) model_edge(r);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    bus.req = 4'b1111;
    rst_n   = 1'b0;
    model_reset();
    #1;
    check_all("rst0");
    for (int i = 0; i < 3; i++) step(4'b1111, "rst_hold");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step(4'b0100, "single");
    async_reset("rst_a");

    for (int i = 0; i < 25; i++) step(4'b1111, "full");
    async_reset("rst_b");

    step(4'b1010, "drop_a");
    step(4'b1010, "drop_b");
    for (int i = 0; i < 6; i++) step(4'b1000, "drop_c");
    async_reset("rst_c");

    for (int i = 0; i < 6; i++) step(4'b1000, "wrap_a");
    for (int i = 0; i < 12; i++) step(4'b1001, "wrap_b");
    async_reset("rst_d");

    for (int i = 0; i < 3; i++) step(4'b0100, "mid_a");
    bus.req = 4'b0110;
    async_reset("mid_rst");
    for (int i = 0; i < 8; i++) step(4'b0110, "mid_b");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) begin
        async_reset("rnd_rst");
      end
      if ($urandom_range(0, 3) == 0) begin
        step(4'($urandom), "rnd");
      end else begin
        step(bus.req, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
